pipeline_skid_buffer: RTL and testbench

PIPELINE_SKID_BUFFER -- requirements
Module: pipeline_skid_buffer

---
 rtl/pipeline_skid_buffer.sv | 152 +++++++++++++++
 tb/tb_pipeline_skid_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_skid_buffer.sv
// rtl/pipeline_skid_buffer.sv - two-entry skid buffer with registered s_ready, flush and transfer counter
//
// Decouples an upstream valid/ready stream from a downstream one without a
// combinational path from m_ready to s_ready. A main register feeds m_data;
// a skid register catches the word that arrives in the cycle the downstream
// stalls, because s_ready was already committed as 1 by then.
//
// Parameters:
//   WIDTH       - data word width (1..1024)
//   RESET_VALUE - value loaded into main and skid registers by reset
//   CNT_WIDTH   - width of xfer_count (1..32)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, highest priority
//   flush      in   synchronous discard of all held words
//   s_valid    in   upstream word valid
//   s_data     in   upstream word
//   s_ready    out  upstream ready, straight from a flop
//   m_valid    out  downstream word valid
//   m_data     out  downstream word (main register)
//   m_ready    in   downstream ready
//   occupancy  out  words held: 0, 1 or 2
//   xfer_count out  output handshake count, wraps

module pipeline_skid_buffer #(
  parameter int                   WIDTH       = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
  parameter int                   CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 s_valid,
  input  logic [WIDTH-1:0]     s_data,
  output logic                 s_ready,
  output logic                 m_valid,
  output logic [WIDTH-1:0]     m_data,
  input  logic                 m_ready,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Declaration initialisers give the reset state at power-up.
  state_t               state     = ST_EMPTY;
  state_t               state_next;
  logic                 s_ready_q = 1'b1;
  logic [WIDTH-1:0]     main_q    = RESET_VALUE;
  logic [WIDTH-1:0]     skid_q    = RESET_VALUE;
  logic [CNT_WIDTH-1:0] count_q   = '0;

  logic in_hs;
  logic out_hs;
  logic load_main;
  logic load_skid;
  logic main_from_skid;
  logic count_inc;

  assign in_hs  = s_valid & s_ready_q;
  assign out_hs = m_valid & m_ready;

  always_comb begin
    state_next     = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;

    case (state)
      ST_EMPTY: begin
        if (in_hs) begin
          load_main  = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_hs && !out_hs) begin
          load_skid  = 1'b1;
          state_next = ST_FULL;
        end else if (out_hs && !in_hs) begin
          state_next = ST_EMPTY;
        end else if (in_hs && out_hs) begin
          load_main  = 1'b1;
        end
      end
      ST_FULL: begin
        // s_ready is 0 here, so in_hs cannot occur.
        if (out_hs) begin
          main_from_skid = 1'b1;
          state_next     = ST_BUSY;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase

    // Flush drops everything in flight, including a same-cycle handshake.
    if (flush) begin
      state_next     = ST_EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  assign count_inc = out_hs & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      s_ready_q <= 1'b1;
    end else begin
      state     <= state_next;
      // Computed from the next state so the flop agrees with the state it accompanies.
      s_ready_q <= (state_next != ST_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
      count_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= s_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= s_data;
      end
      if (count_inc) begin
        count_q <= count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = (state != ST_EMPTY);
  assign m_data     = main_q;
  assign occupancy  = (state == ST_FULL) ? 2'd2 :
                      (state == ST_BUSY) ? 2'd1 : 2'd0;
  assign xfer_count = count_q;

endmodule

// File: tb/tb_pipeline_skid_buffer.sv
// tb/tb_pipeline_skid_buffer.sv - self-checking bench for pipeline_skid_buffer

module tb_pipeline_skid_buffer;

  localparam logic [7:0] RV = 8'h5A;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        m_ready = 1'b0;

  logic        s_ready, m_valid;
  logic [7:0]  m_data;
  logic [1:0]  occupancy;
  logic [15:0] xfer_count;

  logic        s_ready2, m_valid2;
  logic [7:0]  m_data2;
  logic [1:0]  occupancy2;
  logic [1:0]  xfer_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_skid_buffer #(.WIDTH(8), .RESET_VALUE(RV), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .occupancy(occupancy), .xfer_count(xfer_count)
  );

  pipeline_skid_buffer #(.WIDTH(8), .RESET_VALUE(8'h00), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready2),
    .m_valid(m_valid2), .m_data(m_data2), .m_ready(m_ready),
    .occupancy(occupancy2), .xfer_count(xfer_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs, take one rising edge, then settle 1 time unit past it.
  task automatic cyc(input logic r, input logic f, input logic sv,
                     input logic [7:0] sd, input logic mr);
    rst = r; flush = f; s_valid = sv; s_data = sd; m_ready = mr;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       r, f, sv;
    logic [7:0] sd;
    logic       mr;
    logic       e_mv;
    logic [7:0] e_md;
    logic       e_sr;
    logic [1:0] e_occ;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic sv,
                              input logic [7:0] sd, input logic mr,
                              input logic e_mv, input logic [7:0] e_md,
                              input logic e_sr, input logic [1:0] e_occ,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.r = r; v.f = f; v.sv = sv; v.sd = sd; v.mr = mr;
    v.e_mv = e_mv; v.e_md = e_md; v.e_sr = e_sr; v.e_occ = e_occ; v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t vt[22];

  initial begin
    logic [7:0]  q[$];
    logic [15:0] mcnt;
    logic        sv, mr, f, out_hs, in_hs;
    logic [7:0]  sd;
    int          exp_c2[5];

    // Expected values describe outputs after the edge that applies the row.
    //            r  f  sv sd     mr  mv md     sr occ cnt
    vt[0]  = mk(1, 0, 0, 8'h00, 0,  0, RV,    1, 0, 0);  // reset
    vt[1]  = mk(0, 0, 1, 8'hA5, 1,  1, 8'hA5, 1, 1, 0);  // 1-cycle latency
    vt[2]  = mk(0, 0, 0, 8'h00, 1,  0, 8'hA5, 1, 0, 1);  // handshake counted
    vt[3]  = mk(1, 0, 0, 8'h00, 0,  0, RV,    1, 0, 0);
    vt[4]  = mk(0, 0, 1, 8'h11, 0,  1, 8'h11, 1, 1, 0);
    vt[5]  = mk(0, 0, 1, 8'h22, 0,  1, 8'h11, 0, 2, 0);  // FULL
    vt[6]  = mk(0, 0, 1, 8'h33, 0,  1, 8'h11, 0, 2, 0);  // no accept in FULL, data held
    vt[7]  = mk(0, 0, 0, 8'h00, 1,  1, 8'h22, 1, 1, 1);  // 0x11 out
    vt[8]  = mk(0, 0, 0, 8'h00, 1,  0, 8'h22, 1, 0, 2);  // 0x22 out
    vt[9]  = mk(0, 0, 0, 8'h77, 0,  0, 8'h22, 1, 0, 2);  // s_data ignored
    vt[10] = mk(0, 0, 1, 8'h44, 0,  1, 8'h44, 1, 1, 2);
    vt[11] = mk(0, 0, 1, 8'h55, 0,  1, 8'h44, 0, 2, 2);
    vt[12] = mk(0, 1, 1, 8'h33, 0,  0, 8'h44, 1, 0, 2);  // flush from FULL
    vt[13] = mk(0, 0, 1, 8'h66, 0,  1, 8'h66, 1, 1, 2);
    vt[14] = mk(0, 1, 1, 8'h33, 1,  0, 8'h66, 1, 0, 2);  // flush drops both handshakes
    vt[15] = mk(0, 0, 0, 8'h00, 1,  0, 8'h66, 1, 0, 2);
    vt[16] = mk(0, 0, 1, 8'h01, 0,  1, 8'h01, 1, 1, 2);
    vt[17] = mk(0, 0, 1, 8'h02, 0,  1, 8'h01, 0, 2, 2);
    vt[18] = mk(1, 1, 1, 8'h03, 1,  0, RV,    1, 0, 0);  // rst beats flush
    vt[19] = mk(1, 0, 1, 8'h04, 1,  0, RV,    1, 0, 0);  // inputs ignored in reset
    vt[20] = mk(0, 0, 1, 8'h07, 0,  1, 8'h07, 1, 1, 0);
    vt[21] = mk(0, 0, 0, 8'h00, 1,  0, 8'h07, 1, 0, 1);  // first word after reset

    exp_c2 = '{1, 2, 3, 0, 1};

    // Power-up state before any reset edge.
    #1;
    chk("powerup m_valid", 32'(m_valid), 32'(1'b0));
    chk("powerup s_ready", 32'(s_ready), 32'(1'b1));
    chk("powerup m_data", 32'(m_data), 32'(RV));
    chk("powerup xfer_count", 32'(xfer_count), 32'(0));

    for (int i = 0; i < 22; i++) begin
      cyc(vt[i].r, vt[i].f, vt[i].sv, vt[i].sd, vt[i].mr);
      chk($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(vt[i].e_mv));
      chk($sformatf("vec%0d m_data", i), 32'(m_data), 32'(vt[i].e_md));
      chk($sformatf("vec%0d s_ready", i), 32'(s_ready), 32'(vt[i].e_sr));
      chk($sformatf("vec%0d occupancy", i), 32'(occupancy), 32'(vt[i].e_occ));
      chk($sformatf("vec%0d xfer_count", i), 32'(xfer_count), 32'(vt[i].e_cnt));
    end

    // Full-rate stream 0x00..0xFF; the 2-bit counter instance must wrap.
    cyc(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      cyc(0, 0, 1, 8'(i), 1);
      chk($sformatf("stream%0d m_valid", i), 32'(m_valid), 32'(1'b1));
      chk($sformatf("stream%0d m_data", i), 32'(m_data), 32'(i));
      chk($sformatf("stream%0d s_ready", i), 32'(s_ready), 32'(1'b1));
      chk($sformatf("stream%0d xfer_count", i), 32'(xfer_count), 32'(i));
      if (i >= 1 && i <= 5) begin
        chk($sformatf("cnt2 step%0d", i), 32'(xfer_count2), 32'(exp_c2[i-1]));
      end
    end
    cyc(0, 0, 0, 8'h00, 1);
    chk("stream end xfer_count", 32'(xfer_count), 32'(256));
    chk("stream end m_valid", 32'(m_valid), 32'(1'b0));
    chk("stream end cnt2", 32'(xfer_count2), 32'(256 % 4));

    // Random traffic against a queue model: the buffer is a FIFO of depth 2.
    cyc(1, 0, 0, 8'h00, 0);
    mcnt = 16'd0;
    q.delete();
    for (int i = 0; i < 3000; i++) begin
      chk("rnd s_ready", 32'(s_ready), 32'(q.size() < 2));
      chk("rnd m_valid", 32'(m_valid), 32'(q.size() > 0));
      chk("rnd occupancy", 32'(occupancy), 32'(q.size()));
      chk("rnd xfer_count", 32'(xfer_count), 32'(mcnt));
      if (q.size() > 0) begin
        chk("rnd m_data", 32'(m_data), 32'(q[0]));
      end
      sv = ($urandom_range(0, 99) < 70);
      mr = ($urandom_range(0, 99) < 60);
      f  = ($urandom_range(0, 199) == 0);
      sd = 8'($urandom);
      out_hs = (q.size() > 0) && mr;
      in_hs  = sv && (q.size() < 2);
      cyc(0, f, sv, sd, mr);
      if (f) begin
        q.delete();
      end else begin
        if (out_hs) begin
          void'(q.pop_front());
          mcnt = mcnt + 16'd1;
        end
        if (in_hs) begin
          q.push_back(sd);
        end
      end
    end
    chk("rnd final occupancy", 32'(occupancy), 32'(q.size()));
    chk("rnd final xfer_count", 32'(xfer_count), 32'(mcnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
